// File: rtl/e1000_regs_pkg.sv
// e1000_regs_pkg: register offsets, field positions, write masks, MDIC opcodes and a byte-merge helper
package e1000_regs_pkg;
  localparam logic [15:0] EECD_OFF = 16'h0010;
  localparam logic [15:0] EERD_OFF = 16'h0014;
  localparam logic [15:0] MDIC_OFF = 16'h0020;
  localparam int EECD_REQ = 6;
  localparam int EERD_START_B = 0;
  localparam int MDIC_OP_LSB = 26;
  localparam logic [31:0] EECD_MASK = 32'h0000_0077;
  localparam logic [31:0] EECD_PIN_MASK = 32'h0000_0007;
  localparam logic [31:0] EERD_MASK = 32'h0000_FF01;
  localparam logic [31:0] MDIC_MASK = 32'h2FFF_FFFF;
  typedef enum logic [1:0] {
    MDIC_OP_NONE = 2'b00,
    MDIC_OP_WR   = 2'b01,
    MDIC_OP_RD   = 2'b10,
    MDIC_OP_RSVD = 2'b11
  } mdic_op_e;
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] q, input logic [31:0] d, input logic [31:0] m);
    return (q & ~m) | (d & m);
  endfunction
endpackage

// File: rtl/e1000_regs_if.sv
// e1000_regs_if: AXI4-Lite bus (aw/w/b/ar/r channels) with master and slave modports
interface e1000_regs_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/e1000_axil_slave.sv
// e1000_axil_slave: single-outstanding AXI4-Lite handshake; ports aclk/aresetn, axi bus, wr_* strobe port, rd_* lookup port
module e1000_axil_slave (
  input  logic        aclk,
  input  logic        aresetn,
  e1000_regs_if.slave axi,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [31:0] rd_data
);
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  always_comb begin
    wr_en = aresetn && axi.awvalid && axi.wvalid && !bvalid_q;
    rd_en = aresetn && axi.arvalid && !rvalid_q;
    bvalid_d = wr_en || (bvalid_q && !axi.bready);
    rvalid_d = rd_en || (rvalid_q && !axi.rready);
    rdata_d = rd_en ? rd_data : rdata_q;
  end
  assign wr_addr     = axi.awaddr[15:0];
  assign wr_data     = axi.wdata;
  assign wr_strb     = axi.wstrb;
  assign rd_addr     = axi.araddr[15:0];
  assign axi.awready = wr_en;
  assign axi.wready  = wr_en;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = 2'b00;
  assign axi.arready = rd_en;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = 2'b00;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
endmodule

// File: rtl/e1000_regs.sv
// e1000_regs: EECD/EERD/MDIC register block; ports aclk/aresetn, axi_s AXI4-Lite slave, EEPROM (EECD*, EERD*) and MDIO (MDIC*) sideband
module e1000_regs
  import e1000_regs_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  e1000_regs_if.slave axi_s,
  output logic [31:0] EECD,
  input  logic        EECD_DO_i,
  input  logic        EECD_GNT_i,
  output logic [31:0] EERD,
  output logic        EERD_START,
  input  logic        EERD_DONE_i,
  input  logic [15:0] EERD_DATA_i,
  output logic [31:0] MDIC,
  output logic        MDIC_start,
  input  logic        MDIC_R_i,
  input  logic [15:0] MDIC_DATA_i
);
  logic        wr_en, rd_en;
  logic [15:0] wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_strb;
  logic [31:0] eecd_q, eecd_d, eerd_q, eerd_d, mdic_q, mdic_d, bmask, eecd_m;
  logic        eerd_start_q, eerd_start_d, mdic_start_q, mdic_start_d;
  logic        wr_eecd, wr_eerd, wr_mdic;
  mdic_op_e    wr_op, st_op;
  e1000_axil_slave u_slave (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi     (axi_s),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
  always_comb begin
    bmask = strb_mask(wr_strb);
    wr_eecd = wr_en && wr_addr == EECD_OFF;
    wr_eerd = wr_en && wr_addr == EERD_OFF;
    wr_mdic = wr_en && wr_addr == MDIC_OFF;
    eecd_m = bmask & (wr_data[EECD_REQ] ? EECD_MASK : EECD_MASK & ~EECD_PIN_MASK);
    wr_op = mdic_op_e'(wr_data[MDIC_OP_LSB +: 2]);
    st_op = mdic_op_e'(mdic_q[MDIC_OP_LSB +: 2]);
    eecd_d = wr_eecd ? merge(eecd_q, wr_data, eecd_m) : eecd_q;
    eerd_d = wr_eerd ? merge(eerd_q, wr_data, bmask & EERD_MASK) : eerd_q;
    mdic_d = wr_mdic ? merge(mdic_q, wr_data, bmask & MDIC_MASK) : mdic_q;
    eerd_start_d = wr_eerd && wr_strb[0] && wr_data[EERD_START_B];
    mdic_start_d = wr_mdic && wr_strb[3] && (wr_op == MDIC_OP_WR || wr_op == MDIC_OP_RD);
    rd_data = !rd_en ? '0
            : rd_addr == EECD_OFF ? {23'b0, 1'b1, eecd_q[EECD_REQ] & EECD_GNT_i, eecd_q[6:4], EECD_DO_i, eecd_q[2:0]}
            : rd_addr == EERD_OFF ? {EERD_DATA_i, eerd_q[15:8], 3'b0, EERD_DONE_i, 3'b0, eerd_q[0]}
            : rd_addr == MDIC_OFF ? {mdic_q[31:29], MDIC_R_i, mdic_q[27:16], (st_op == MDIC_OP_RD) ? MDIC_DATA_i : mdic_q[15:0]}
            : '0;
  end
  assign EECD       = eecd_q;
  assign EERD       = eerd_q;
  assign MDIC       = mdic_q;
  assign EERD_START = eerd_start_q;
  assign MDIC_start = mdic_start_q;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      eecd_q       <= '0;
      eerd_q       <= '0;
      mdic_q       <= '0;
      eerd_start_q <= 1'b0;
      mdic_start_q <= 1'b0;
    end else begin
      eecd_q       <= eecd_d;
      eerd_q       <= eerd_d;
      mdic_q       <= mdic_d;
      eerd_start_q <= eerd_start_d;
      mdic_start_q <= mdic_start_d;
    end
endmodule

// File: tb/tb_e1000_regs.sv
// tb_e1000_regs: scoreboard bench for e1000_regs covering EECD, EERD, MDIC, strobes, unmapped access, stalls and reset
module tb_e1000_regs;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        eecd_do_i = 1'b0, eecd_gnt_i = 1'b0, eerd_done_i = 1'b0, mdic_r_i = 1'b0;
  logic [15:0] eerd_data_i = '0, mdic_data_i = '0;
  logic [31:0] eecd, eerd, mdic;
  logic        eerd_start, mdic_start;
  int          vectors = 0, miscompares = 0;
  int          eerd_pulses = 0, mdic_pulses = 0;
  logic [31:0] eerd_at_pulse = '0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  e1000_regs_if axi_s();
  e1000_regs dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .axi_s       (axi_s),
    .EECD        (eecd),
    .EECD_DO_i   (eecd_do_i),
    .EECD_GNT_i  (eecd_gnt_i),
    .EERD        (eerd),
    .EERD_START  (eerd_start),
    .EERD_DONE_i (eerd_done_i),
    .EERD_DATA_i (eerd_data_i),
    .MDIC        (mdic),
    .MDIC_start  (mdic_start),
    .MDIC_R_i    (mdic_r_i),
    .MDIC_DATA_i (mdic_data_i)
  );
  always #5 aclk = ~aclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge aclk) begin
    if (eerd_start) begin
      eerd_pulses++;
      eerd_at_pulse = eerd;
    end
    if (mdic_start) mdic_pulses++;
  end
  always @(negedge aclk)
    if (aresetn && axi_s.rvalid && axi_s.rready) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'(exp_q.size()), 1);
      else begin
        check(tag_q.pop_front(), axi_s.rdata, exp_q.pop_front());
        check("rresp", 32'(axi_s.rresp), 0);
      end
    end
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hf);
    int n = 0;
    @(posedge aclk); #1;
    axi_s.awvalid = 1'b1; axi_s.awaddr = a; axi_s.wvalid = 1'b1; axi_s.wdata = d; axi_s.wstrb = s;
    @(negedge aclk);
    while (!(axi_s.awready && axi_s.wready) && n < 20) begin n++; @(negedge aclk); end
    check("wr_hs", 32'(axi_s.awready && axi_s.wready), 1);
    @(posedge aclk); #1;
    axi_s.awvalid = 1'b0; axi_s.wvalid = 1'b0;
    n = 0;
    while (!axi_s.bvalid && n < 20) begin n++; @(negedge aclk); end
    check("bvalid", 32'(axi_s.bvalid), 1);
    check("bresp", 32'(axi_s.bresp), 0);
    @(posedge aclk); #1;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int n = 0;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge aclk); #1;
    axi_s.arvalid = 1'b1; axi_s.araddr = a;
    @(negedge aclk);
    while (!axi_s.arready && n < 20) begin n++; @(negedge aclk); end
    @(posedge aclk); #1;
    axi_s.arvalid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin n++; @(negedge aclk); end
    check({tag, "_done"}, 32'(exp_q.size()), 0);
  endtask
  initial begin
    int p0;
    axi_s.awvalid = 1'b1; axi_s.awaddr = 32'h14; axi_s.wvalid = 1'b1; axi_s.wdata = 32'h1; axi_s.wstrb = 4'hf;
    axi_s.bready = 1'b1; axi_s.arvalid = 1'b1; axi_s.araddr = 32'h10; axi_s.rready = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_awready", 32'(axi_s.awready), 0);
    check("rst_arready", 32'(axi_s.arready), 0);
    check("rst_bvalid", 32'(axi_s.bvalid), 0);
    check("rst_rvalid", 32'(axi_s.rvalid), 0);
    check("rst_regs", eecd | eerd | mdic, 0);
    check("rst_starts", 32'(eerd_start | mdic_start), 0);
    axi_s.awvalid = 1'b0; axi_s.wvalid = 1'b0; axi_s.arvalid = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    eecd_gnt_i = 1'b1;
    wr(32'h10, 32'h60);
    check("eecd_out_60", eecd, 32'h60);
    rd("eecd_rd_60", 32'h10, 32'h1E0);
    wr(32'h10, 32'h64);
    check("eecd_pins_64", eecd & 32'h7, 32'h4);
    wr(32'h10, 32'h20);
    wr(32'h10, 32'h07);
    check("eecd_pins_kept", eecd & 32'h7, 32'h4);
    rd("eecd_rd_07", 32'h10, 32'h104);
    eecd_do_i = 1'b1;
    rd("eecd_do1", 32'h10, 32'h10C);
    eecd_do_i = 1'b0;
    rd("eecd_do0", 32'h10, 32'h104);
    wr(32'h10, 32'h77, 4'h0);
    rd("eecd_strb0", 32'h10, 32'h104);
    p0 = eerd_pulses;
    wr(32'h14, 32'h0000FF01);
    repeat (2) @(negedge aclk);
    check("eerd_pulses", 32'(eerd_pulses - p0), 1);
    check("eerd_at_pulse", eerd_at_pulse, 32'h0000FF01);
    check("eerd_out", eerd, 32'h0000FF01);
    eerd_done_i = 1'b1; eerd_data_i = 16'hBEEF;
    rd("eerd_rd", 32'h14, 32'hBEEFFF11);
    p0 = eerd_pulses;
    wr(32'h14, 32'h0000FF00);
    repeat (2) @(negedge aclk);
    check("eerd_nostart", 32'(eerd_pulses - p0), 0);
    rd("eerd_rd_ns", 32'h14, 32'hBEEFFF10);
    p0 = mdic_pulses;
    wr(32'h20, 32'h0401ABCD);
    repeat (2) @(negedge aclk);
    check("mdic_wr_pulses", 32'(mdic_pulses - p0), 1);
    check("mdic_out", mdic, 32'h0401ABCD);
    mdic_r_i = 1'b1;
    rd("mdic_rd_w", 32'h20, 32'h1401ABCD);
    p0 = mdic_pulses;
    wr(32'h20, 32'h08010000);
    mdic_data_i = 16'hAA55;
    repeat (2) @(negedge aclk);
    check("mdic_rd_pulses", 32'(mdic_pulses - p0), 1);
    rd("mdic_rd_r", 32'h20, 32'h1801AA55);
    p0 = mdic_pulses;
    wr(32'h20, 32'h04021234, 4'b0111);
    repeat (2) @(negedge aclk);
    check("mdic_strb_pulses", 32'(mdic_pulses - p0), 0);
    check("mdic_strb_out", mdic, 32'h08021234);
    exp_q.push_back(32'h1802AA55);
    tag_q.push_back("rw_same_cycle");
    @(posedge aclk); #1;
    axi_s.awvalid = 1'b1; axi_s.awaddr = 32'h20; axi_s.wvalid = 1'b1; axi_s.wdata = 32'h00001234; axi_s.wstrb = 4'hf;
    axi_s.arvalid = 1'b1; axi_s.araddr = 32'h20;
    @(negedge aclk);
    check("rw_both_ready", 32'(axi_s.awready && axi_s.arready), 1);
    @(posedge aclk); #1;
    axi_s.awvalid = 1'b0; axi_s.wvalid = 1'b0; axi_s.arvalid = 1'b0;
    repeat (3) @(negedge aclk);
    check("rw_popped", 32'(exp_q.size()), 0);
    rd("mdic_after_rw", 32'h20, 32'h10001234);
    rd("unmapped_rd", 32'h100, 32'h0);
    wr(32'h100, 32'hFFFFFFFF);
    rd("unmapped_rd2", 32'h100, 32'h0);
    rd("eecd_after_unmapped", 32'h10, 32'h104);
    axi_s.bready = 1'b0;
    @(posedge aclk); #1;
    axi_s.awvalid = 1'b1; axi_s.awaddr = 32'h14; axi_s.wvalid = 1'b1; axi_s.wdata = 32'h0000AB00; axi_s.wstrb = 4'hf;
    @(negedge aclk);
    check("stall_hs1", 32'(axi_s.awready), 1);
    @(posedge aclk); #1 axi_s.wdata = 32'h0000CD00;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("stall_bvalid", 32'(axi_s.bvalid), 1);
      check("stall_awready", 32'(axi_s.awready), 0);
    end
    axi_s.bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("stall_hs2", 32'(axi_s.awready), 1);
    @(posedge aclk); #1;
    axi_s.awvalid = 1'b0; axi_s.wvalid = 1'b0;
    @(posedge aclk); #1;
    check("stall_eerd", eerd, 32'h0000CD00);
    rd("stall_eerd_rd", 32'h14, 32'hBEEFCD10);
    axi_s.bready = 1'b0;
    @(posedge aclk); #1;
    axi_s.awvalid = 1'b1; axi_s.awaddr = 32'h10; axi_s.wvalid = 1'b1; axi_s.wdata = 32'h60;
    @(posedge aclk); #1;
    axi_s.awvalid = 1'b0; axi_s.wvalid = 1'b0;
    @(negedge aclk);
    check("mid_bvalid", 32'(axi_s.bvalid), 1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_bvalid", 32'(axi_s.bvalid), 0);
    check("mid_rst_eecd", eecd, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1; axi_s.bready = 1'b1;
    repeat (3) @(negedge aclk);
    check("mid_no_resp", 32'(axi_s.bvalid), 0);
    rd("eecd_after_rst", 32'h10, 32'h100);
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/e1000_regs.md
E1000_REGS -- requirements
Module: e1000_regs

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: aclk in 1 (all logic on rising edge); aresetn in 1 (asynchronous, active-low).
REQ-002 SHALL provide the AXI4-Lite write channels:
- axi_s_awvalid in 1; axi_s_awready out 1; axi_s_awaddr in 32.
- axi_s_wvalid in 1; axi_s_wready out 1; axi_s_wdata in 32; axi_s_wstrb in 4.
- axi_s_bvalid out 1; axi_s_bready in 1; axi_s_bresp out 2.
REQ-003 SHALL provide the AXI4-Lite read channels:
- axi_s_arvalid in 1; axi_s_arready out 1; axi_s_araddr in 32.
- axi_s_rvalid out 1; axi_s_rready in 1; axi_s_rdata out 32; axi_s_rresp out 2.
REQ-004 SHALL provide the EEPROM ports:
- EECD out 32: stored EECD bits. EECD_DO_i in 1: serial EEPROM data out. EECD_GNT_i in 1: auto-read engine idle.
- EERD out 32: stored EERD. EERD_START out 1: one-cycle auto-read start. EERD_DONE_i in 1: read done. EERD_DATA_i in 16: read word.
REQ-005 SHALL provide the MDIO ports: MDIC out 32 (stored MDIC); MDIC_start out 1 (one-cycle MDIO start); MDIC_R_i in 1 (MDIO transaction ready); MDIC_DATA_i in 16 (MDIO read data).

Function
REQ-006 SHALL decode awaddr/araddr[15:0]: EECD 0x0010, EERD 0x0014, MDIC 0x0020; other offsets read 0 and ignore writes.
REQ-007 SHALL make every response OKAY (bresp = rresp = 2'b00).
REQ-008 SHALL handle writes with one outstanding transaction:
- awready and wready both assert for one cycle when awvalid and wvalid are both high and bvalid is low.
- The register updates on that cycle; bvalid rises the next cycle and holds until bready.
REQ-009 SHALL handle reads with one outstanding transaction: arready pulses when arvalid is high and rvalid is low; rdata is registered; rvalid rises the next cycle and holds until rready.
REQ-010 SHALL apply wstrb byte-wise to stored register bits; start pulses fire only when the byte holding the start/opcode bit is enabled.
REQ-011 SHALL implement EECD:
- Fields: SK[0], CS[1], DI[2], FWE[5:4], REQ[6] stored.
- SK/CS/DI update only on writes with wdata[6]=1; FWE and REQ always update.
- Read value: stored bits; bit3 = EECD_DO_i; bit7 GNT = REQ & EECD_GNT_i; bit8 PRES = 1; other bits 0.
REQ-012 SHALL implement EERD:
- A write stores START[0] and ADDR[15:8].
- A write with wdata[0]=1 pulses EERD_START for exactly one cycle, the cycle after the write handshake; EERD output is stable before and during the pulse.
- Read value: {EERD_DATA_i, ADDR, 3'b0, EERD_DONE_i, 3'b0, START}.
REQ-013 SHALL implement MDIC:
- A write stores DATA[15:0], REGADD[20:16], PHYADD[25:21], OP[27:26], I[29].
- Every MDIC write with OP = 01 (write) or 10 (read) pulses MDIC_start for one cycle after the handshake.
- Read value: bit28 R = MDIC_R_i; bit30 E = 0; bits15:0 = MDIC_DATA_i when OP=10, otherwise stored DATA; other fields as stored.
REQ-014 SHALL give a read issued in the same cycle as a write the pre-write value.

Reset
REQ-015 SHALL, while aresetn is low, clear all stored registers, EERD_START, MDIC_start, awready, wready, arready, bvalid and rvalid; outputs EECD/EERD/MDIC read 0.
REQ-016 SHALL, when reset is asserted mid-transaction, drop the transaction with no response; the master re-issues.

Structure
REQ-017 SHALL place register offsets, field bit positions and OP encodings in a shared package e1000_regs_pkg.
REQ-018 SHALL use one natural sub-module, e1000_axil_slave (AXI-Lite handshake to a simple wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data port); register decode stays in e1000_regs.

Verification
REQ-019 SHALL verify EECD request: write EECD 0x60 with EECD_GNT_i=1 -> read bit7=1, bit6=1; write 0x64 -> EECD[2:0]=3'b100; write 0x20 then 0x07 -> EECD[2:0] unchanged, read bit7=0.
REQ-020 SHALL verify DO reflection: EECD_DO_i=1 -> EECD read bit3=1; EECD_DO_i=0 -> bit3=0.
REQ-021 SHALL verify EERD auto-read: write 0x0000FF01 -> one EERD_START pulse, EERD[15:8]=0xFF; DONE_i=1, DATA_i=0xBEEF -> read 0xBEEFFF11.
REQ-022 SHALL verify MDIC write: write 0x0401ABCD (OP=01, PHY 0, REG 1, data 0xABCD) -> one MDIC_start pulse, MDIC=0x0401ABCD; R_i=1 -> read bit28=1.
REQ-023 SHALL verify MDIC read: write 0x08010000; MDIC_DATA_i=0xAA55, R_i=1 -> read 0x1801AA55.
REQ-024 SHALL verify unmapped access and handshake: read 0x0100 -> 0 with OKAY; bready held low 5 cycles -> bvalid held, no second awready.
